// File: rtl/riscv_pkg.sv
// Shared RISC-V core types: memory-op encoding and helpers for access size and direction.
package riscv_pkg;

  localparam int XLEN = 32;

  typedef enum logic [3:0] {
    MEM_NONE = 4'd0,
    MEM_LB   = 4'd1,
    MEM_LH   = 4'd2,
    MEM_LW   = 4'd3,
    MEM_LBU  = 4'd4,
    MEM_LHU  = 4'd5,
    MEM_SB   = 4'd6,
    MEM_SH   = 4'd7,
    MEM_SW   = 4'd8
  } mem_op_e;

  typedef enum logic [1:0] {
    SIZE_B = 2'd0,
    SIZE_H = 2'd1,
    SIZE_W = 2'd2
  } access_size_e;

  function automatic logic is_load(input mem_op_e op);
    return (op == MEM_LB) || (op == MEM_LH) || (op == MEM_LW) ||
           (op == MEM_LBU) || (op == MEM_LHU);
  endfunction

  function automatic logic is_store(input mem_op_e op);
    return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
  endfunction

  function automatic access_size_e access_size(input mem_op_e op);
    case (op)
      MEM_LB, MEM_LBU, MEM_SB: return SIZE_B;
      MEM_LH, MEM_LHU, MEM_SH: return SIZE_H;
      default:                 return SIZE_W;
    endcase
  endfunction

  // Only half and word accesses can be misaligned; NONE ops never are.
  function automatic logic is_misaligned(input mem_op_e op, input logic [1:0] byte_off);
    if (!(is_load(op) || is_store(op))) return 1'b0;
    case (access_size(op))
      SIZE_H:  return byte_off[0];
      SIZE_W:  return |byte_off;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_data_align.sv
// Combinational lane steering: byte enables and replicated write data for stores,
// byte/half extraction with sign or zero extension for loads.
module lsu_data_align (
  input  logic [3:0]                 mem_op,
  input  logic [1:0]                 byte_off,
  input  logic [riscv_pkg::XLEN-1:0] store_data,
  input  logic [riscv_pkg::XLEN-1:0] load_word,
  output logic [3:0]                 be,
  output logic [riscv_pkg::XLEN-1:0] wdata,
  output logic [riscv_pkg::XLEN-1:0] load_data
);
  import riscv_pkg::*;

  mem_op_e     op;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  assign op       = mem_op_e'(mem_op);
  assign sel_byte = load_word[{byte_off, 3'b000} +: 8];
  assign sel_half = byte_off[1] ? load_word[31:16] : load_word[15:0];

  // Half and word lanes ignore the low offset bits, so misaligned addresses fold down.
  always_comb begin
    be    = 4'b0000;
    wdata = '0;
    case (access_size(op))
      SIZE_B: begin
        be    = 4'b0001 << byte_off;
        wdata = {4{store_data[7:0]}};
      end
      SIZE_H: begin
        be    = byte_off[1] ? 4'b1100 : 4'b0011;
        wdata = {2{store_data[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wdata = store_data;
      end
    endcase
  end

  always_comb begin
    load_data = '0;
    case (op)
      MEM_LB:  load_data = {{24{sel_byte[7]}}, sel_byte};
      MEM_LBU: load_data = {24'h000000, sel_byte};
      MEM_LH:  load_data = {{16{sel_half[15]}}, sel_half};
      MEM_LHU: load_data = {16'h0000, sel_half};
      MEM_LW:  load_data = load_word;
      default: load_data = '0;
    endcase
  end

endmodule

// File: rtl/lsu_mem_stage.sv
// Memory-access stage: one outstanding data-memory transaction, aligned write-back data.
// Define MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of folding the address.
module lsu_mem_stage #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [XLEN-1:0]   ex_alu_result,
  input  logic [XLEN-1:0]   ex_store_data,
  input  logic [3:0]        ex_mem_op,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_reg_write,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic              mem_we,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [3:0]        mem_be,
  input  logic              mem_rvalid,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [XLEN-1:0]   wb_data,
  output logic [REG_AW-1:0] wb_rd,
  output logic              wb_reg_write,
  output logic              wb_exc
);
  import riscv_pkg::*;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_OUT
  } state_e;

  state_e            state, state_next;
  mem_op_e           ex_op, op_q;
  logic [XLEN-1:0]   addr_q, sdata_q;
  logic [REG_AW-1:0] rd_q;
  logic              reg_write_q;
  logic              accept, fault, direct_out, rsp_done;
  logic [3:0]        align_be;
  logic [XLEN-1:0]   align_wdata, align_load;

  assign ex_op = mem_op_e'(ex_mem_op);

`ifdef MISALIGN_TRAP_EN
  assign fault = is_misaligned(ex_op, ex_alu_result[1:0]);
`else
  assign fault = 1'b0;
`endif

  // Unknown op codes are treated like NONE so they can never stall the bus.
  assign direct_out = !(is_load(ex_op) || is_store(ex_op)) || fault;
  assign ex_ready   = (state == S_IDLE) || ((state == S_OUT) && wb_ready);
  assign accept     = ex_valid && ex_ready;
  assign rsp_done   = (state == S_WAIT) && mem_rvalid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE, S_OUT: begin
        if (accept)                          state_next = direct_out ? S_OUT : S_REQ;
        else if ((state == S_OUT) && wb_ready) state_next = S_IDLE;
      end
      S_REQ:   if (mem_gnt)    state_next = S_WAIT;
      S_WAIT:  if (mem_rvalid) state_next = S_OUT;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q        <= MEM_NONE;
      addr_q      <= '0;
      sdata_q     <= '0;
      rd_q        <= '0;
      reg_write_q <= 1'b0;
    end else if (accept) begin
      op_q        <= ex_op;
      addr_q      <= ex_alu_result;
      sdata_q     <= ex_store_data;
      rd_q        <= ex_rd;
      reg_write_q <= ex_reg_write;
    end
  end

  // Write-back registers only change on entry to OUT, so a stalled WB sees them frozen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_data      <= '0;
      wb_rd        <= '0;
      wb_reg_write <= 1'b0;
    end else if (accept && direct_out) begin
      wb_data      <= ex_alu_result;
      wb_rd        <= ex_rd;
      wb_reg_write <= ex_reg_write && !fault;
    end else if (rsp_done) begin
      wb_data      <= is_load(op_q) ? align_load : addr_q;
      wb_rd        <= rd_q;
      wb_reg_write <= is_load(op_q) && reg_write_q;
    end
  end

`ifdef MISALIGN_TRAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    wb_exc <= 1'b0;
    else if (accept && direct_out) wb_exc <= fault;
    else if (rsp_done)             wb_exc <= 1'b0;
  end
`else
  assign wb_exc = 1'b0;
`endif

  lsu_data_align u_align (
    .mem_op     (op_q),
    .byte_off   (addr_q[1:0]),
    .store_data (sdata_q),
    .load_word  (mem_rdata),
    .be         (align_be),
    .wdata      (align_wdata),
    .load_data  (align_load)
  );

  assign wb_valid  = (state == S_OUT);
  assign mem_req   = (state == S_REQ);
  assign mem_we    = mem_req && is_store(op_q);
  assign mem_addr  = mem_req ? {addr_q[XLEN-1:2], 2'b00} : '0;
  assign mem_be    = mem_req ? align_be : 4'b0000;
  assign mem_wdata = mem_we ? align_wdata : '0;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed bench for lsu_mem_stage: pass-through, load formatting, store lanes, stalls, reset.
module tb_lsu_mem_stage;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_valid, ex_ready;
  logic [31:0] ex_alu_result, ex_store_data;
  logic [3:0]  ex_mem_op;
  logic [4:0]  ex_rd;
  logic        ex_reg_write;
  logic        mem_req, mem_gnt, mem_we, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        wb_valid, wb_ready, wb_reg_write, wb_exc;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lsu_mem_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ex_valid      (ex_valid),
    .ex_ready      (ex_ready),
    .ex_alu_result (ex_alu_result),
    .ex_store_data (ex_store_data),
    .ex_mem_op     (ex_mem_op),
    .ex_rd         (ex_rd),
    .ex_reg_write  (ex_reg_write),
    .mem_req       (mem_req),
    .mem_gnt       (mem_gnt),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_be        (mem_be),
    .mem_rvalid    (mem_rvalid),
    .mem_rdata     (mem_rdata),
    .wb_valid      (wb_valid),
    .wb_ready      (wb_ready),
    .wb_data       (wb_data),
    .wb_rd         (wb_rd),
    .wb_reg_write  (wb_reg_write),
    .wb_exc        (wb_exc)
  );

  // A response while the request is still pending is a bus protocol violation.
  always @(posedge clk)
    if (rst_n && mem_req && mem_rvalid)
      $error("[TB] protocol error: rvalid while mem_req pending");

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input mem_op_e op, input logic [31:0] alu, input logic [31:0] sdata,
                               input logic [4:0] rd, input logic rw);
    ex_valid      = 1'b1;
    ex_mem_op     = op;
    ex_alu_result = alu;
    ex_store_data = sdata;
    ex_rd         = rd;
    ex_reg_write  = rw;
  endtask

  task automatic checkWb(input logic [31:0] data, input logic [4:0] rd, input logic rw, input logic exc);
    checkOutput("wb_valid", wb_valid, 1);
    checkOutput("wb_data", wb_data, data);
    checkOutput("wb_rd", wb_rd, rd);
    checkOutput("wb_reg_write", wb_reg_write, rw);
    checkOutput("wb_exc", wb_exc, exc);
  endtask

  // Called at the negedge where an op was just presented; returns with the stage in OUT.
  task automatic memCycle(input int gntDelay, input logic [31:0] rdata, input logic [31:0] expAddr,
                          input logic [3:0] expBe, input logic [31:0] expWdata, input logic expWe);
    @(negedge clk);
    ex_valid = 1'b0;
    for (int i = 0; i <= gntDelay; i++) begin
      checkOutput("req_mem_req", mem_req, 1);
      checkOutput("req_mem_addr", mem_addr, expAddr);
      checkOutput("req_mem_be", mem_be, expBe);
      checkOutput("req_mem_wdata", mem_wdata, expWdata);
      checkOutput("req_mem_we", mem_we, expWe);
      checkOutput("req_ex_ready", ex_ready, 0);
      if (i == gntDelay) mem_gnt = 1'b1;
      @(negedge clk);
      mem_gnt = 1'b0;
    end
    checkOutput("wait_mem_req", mem_req, 0);
    checkOutput("wait_wb_valid", wb_valid, 0);
    mem_rvalid = 1'b1;
    mem_rdata  = rdata;
    @(negedge clk);
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
  endtask

  initial begin
    ex_valid = 1'b0; ex_alu_result = '0; ex_store_data = '0; ex_mem_op = MEM_NONE;
    ex_rd = '0; ex_reg_write = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    mem_rdata = '0; wb_ready = 1'b1;

    repeat (2) @(negedge clk);
    checkOutput("rst_wb_valid", wb_valid, 0);
    checkOutput("rst_mem_req", mem_req, 0);
    checkOutput("rst_mem_we", mem_we, 0);
    checkOutput("rst_wb_reg_write", wb_reg_write, 0);
    checkOutput("rst_wb_exc", wb_exc, 0);
    checkOutput("rst_wb_data", wb_data, 0);
    checkOutput("rst_ex_ready", ex_ready, 1);
    rst_n = 1'b1;
    @(negedge clk);

    // Back-to-back ALU pass-through
    applyStimulus(MEM_NONE, 32'h1, 32'h0, 5'd1, 1'b1);
    @(negedge clk);
    checkWb(32'h1, 5'd1, 1'b1, 1'b0);
    checkOutput("pass_ex_ready", ex_ready, 1);
    applyStimulus(MEM_NONE, 32'h2, 32'h0, 5'd2, 1'b1);
    @(negedge clk);
    checkWb(32'h2, 5'd2, 1'b1, 1'b0);
    applyStimulus(MEM_NONE, 32'h3, 32'h0, 5'd3, 1'b0);
    @(negedge clk);
    checkWb(32'h3, 5'd3, 1'b0, 1'b0);
    ex_valid = 1'b0;
    @(negedge clk);
    checkOutput("pass_idle_wb_valid", wb_valid, 0);

    // Loads: sign/zero-extended byte, sign-extended upper half
    applyStimulus(MEM_LB, 32'h1003, 32'h0, 5'd10, 1'b1);
    memCycle(0, 32'h80FF_1234, 32'h1000, 4'b1000, 32'h0, 1'b0);
    checkWb(32'hFFFF_FF80, 5'd10, 1'b1, 1'b0);
    applyStimulus(MEM_LBU, 32'h1003, 32'h0, 5'd11, 1'b1);
    memCycle(0, 32'h80FF_1234, 32'h1000, 4'b1000, 32'h0, 1'b0);
    checkWb(32'h0000_0080, 5'd11, 1'b1, 1'b0);
    applyStimulus(MEM_LH, 32'h6002, 32'h0, 5'd12, 1'b1);
    memCycle(0, 32'h8001_7FFF, 32'h6000, 4'b1100, 32'h0, 1'b0);
    checkWb(32'hFFFF_8001, 5'd12, 1'b1, 1'b0);

    // Stores: half in upper lanes, byte in lane 1, word with delayed grant
    applyStimulus(MEM_SH, 32'h2002, 32'h0000_BEEF, 5'd13, 1'b1);
    memCycle(0, 32'h0, 32'h2000, 4'b1100, 32'hBEEF_BEEF, 1'b1);
    checkOutput("sh_wb_valid", wb_valid, 1);
    checkOutput("sh_wb_reg_write", wb_reg_write, 0);
    applyStimulus(MEM_SB, 32'h7001, 32'h1234_56A5, 5'd14, 1'b1);
    memCycle(0, 32'h0, 32'h7000, 4'b0010, 32'hA5A5_A5A5, 1'b1);
    checkOutput("sb_wb_reg_write", wb_reg_write, 0);
    applyStimulus(MEM_SW, 32'h4000, 32'h1234_5678, 5'd15, 1'b1);
    memCycle(4, 32'h0, 32'h4000, 4'b1111, 32'h1234_5678, 1'b1);
    checkOutput("sw_wb_valid", wb_valid, 1);
    checkOutput("sw_wb_reg_write", wb_reg_write, 0);

    // Write-back stall holds the result and blocks the next op
    applyStimulus(MEM_NONE, 32'hAA, 32'h0, 5'd7, 1'b1);
    @(negedge clk);
    checkWb(32'hAA, 5'd7, 1'b1, 1'b0);
    wb_ready = 1'b0;
    applyStimulus(MEM_NONE, 32'hBB, 32'h0, 5'd8, 1'b1);
    for (int i = 0; i < 3; i++) begin
      #1 checkOutput("stall_ex_ready", ex_ready, 0);
      @(negedge clk);
      checkWb(32'hAA, 5'd7, 1'b1, 1'b0);
    end
    wb_ready = 1'b1;
    #1 checkOutput("resume_ex_ready", ex_ready, 1);
    @(negedge clk);
    checkWb(32'hBB, 5'd8, 1'b1, 1'b0);
    ex_valid = 1'b0;
    @(negedge clk);
    checkOutput("resume_idle_wb_valid", wb_valid, 0);

    // Misaligned word load
    applyStimulus(MEM_LW, 32'h3001, 32'h0, 5'd16, 1'b1);
`ifdef MISALIGN_TRAP_EN
    @(negedge clk);
    ex_valid = 1'b0;
    checkOutput("trap_mem_req", mem_req, 0);
    checkWb(32'h3001, 5'd16, 1'b0, 1'b1);
`else
    memCycle(0, 32'hCAFE_F00D, 32'h3000, 4'b1111, 32'h0, 1'b0);
    checkWb(32'hCAFE_F00D, 5'd16, 1'b1, 1'b0);
`endif
    @(negedge clk);
    checkOutput("lw_idle_wb_valid", wb_valid, 0);

    // Reset while waiting for the response, then a stray late response
    applyStimulus(MEM_LW, 32'h5000, 32'h0, 5'd17, 1'b1);
    @(negedge clk);
    ex_valid = 1'b0;
    checkOutput("rw_mem_req", mem_req, 1);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    checkOutput("rw_wait_ex_ready", ex_ready, 0);
    rst_n = 1'b0;
    #1;
    checkOutput("rw_rst_ex_ready", ex_ready, 1);
    checkOutput("rw_rst_mem_req", mem_req, 0);
    checkOutput("rw_rst_wb_valid", wb_valid, 0);
    @(negedge clk);
    rst_n      = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hDEAD_BEEF;
    @(negedge clk);
    mem_rvalid = 1'b0;
    checkOutput("late_rvalid_wb_valid", wb_valid, 0);
    @(negedge clk);
    checkOutput("late_rvalid_wb_valid2", wb_valid, 0);
    checkOutput("late_rvalid_mem_req", mem_req, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
